// File: rtl/nw_pkg.sv
// nw_pkg: shared definitions for the Needleman-Wunsch engine.
//   - 2-bit base encoding and the 3-bit gap symbol used on output pairs
//   - traceback move type and FSM state type
//   - default score width and scoring constants shared with the fill stage
package nw_pkg;
  localparam logic [1:0] BASE_A  = 2'd0;
  localparam logic [1:0] BASE_C  = 2'd1;
  localparam logic [1:0] BASE_G  = 2'd2;
  localparam logic [1:0] BASE_T  = 2'd3;
  localparam logic [2:0] GAP_SYM = 3'd4;

  localparam int DEF_SCORE_W  = 8;
  localparam int DEF_MATCH    = 1;
  localparam int DEF_MISMATCH = -1;
  localparam int DEF_GAP      = -1;

  typedef enum logic [1:0] {DIAG, UP, LEFT} move_t;

  typedef enum logic [3:0] {
    IDLE, RD_CUR, WAIT_CUR, RD_DIAG, WAIT_DIAG, RD_UP, WAIT_UP, DECIDE, EMIT, DONE
  } state_t;
endpackage

// File: rtl/nw_tb_decide.sv
// nw_tb_decide: combinational move/pair selector for the traceback walk.
//   cur, d, u       : current cell score and its diagonal / up neighbour scores
//   i, j            : cell coordinates being stepped from
//   base_a, base_b  : a[i-1] and b[j-1]
//   mv              : chosen move, used to build the output pair
//   diag_ok, up_ok  : cur is explained by a diagonal / up predecessor
//   at_origin       : walk has reached (0,0)
//   on_edge         : row or column 0, move is forced (edge_mv)
//   pair_a, pair_b  : output symbols for mv (4 = gap)
module nw_tb_decide import nw_pkg::*; #(
  parameter int SCORE_W  = DEF_SCORE_W,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int GAP      = DEF_GAP,
  parameter int IW       = 3
) (
  input  logic signed [SCORE_W-1:0] cur,
  input  logic signed [SCORE_W-1:0] d,
  input  logic signed [SCORE_W-1:0] u,
  input  logic        [IW-1:0]      i,
  input  logic        [IW-1:0]      j,
  input  logic        [1:0]         base_a,
  input  logic        [1:0]         base_b,
  input  move_t                     mv,
  output logic                      diag_ok,
  output logic                      up_ok,
  output logic                      at_origin,
  output logic                      on_edge,
  output move_t                     edge_mv,
  output logic        [2:0]         pair_a,
  output logic        [2:0]         pair_b
);
  // One extra bit so score + bonus/penalty can never wrap.
  logic [SCORE_W:0] cur_x, bonus, d_sum, u_sum;

  assign cur_x = {cur[SCORE_W-1], cur};
  assign bonus = (base_a == base_b) ? (SCORE_W+1)'(MATCH) : (SCORE_W+1)'(MISMATCH);
  assign d_sum = {d[SCORE_W-1], d} + bonus;
  assign u_sum = {u[SCORE_W-1], u} + (SCORE_W+1)'(GAP);

  assign diag_ok   = (cur_x == d_sum);
  assign up_ok     = (cur_x == u_sum);
  assign at_origin = (i == '0) && (j == '0);
  assign on_edge   = (i == '0) || (j == '0);
  assign edge_mv   = (i == '0) ? LEFT : UP;

  always_comb begin
    pair_a = {1'b0, base_a};
    pair_b = {1'b0, base_b};
    case (mv)
      UP:      pair_b = GAP_SYM;
      LEFT:    pair_a = GAP_SYM;
      default: ;
    endcase
  end
endmodule

// File: rtl/nw_traceback.sv
// nw_traceback: traceback stage of the Needleman-Wunsch engine.
// Walks the filled score matrix from (SEQ_LEN,SEQ_LEN) to (0,0), emitting one
// aligned pair per move (last column first) on a valid/ready stream.
// Ports:
//   clk, rst (sync, active low), en_traceB (level enable from controller)
//   seq_a, seq_b        : packed 2-bit bases, base k at [2k+1:2k]
//   rd_en, rd_i, rd_j   : matrix read request; rd_score returns one cycle later
//   out_valid/out_ready : pair stream, out_a/out_b symbols (4 = gap)
//   end_traceB          : one-cycle completion pulse
// Optional: macro TB_STATS_EN adds aln_len (handshaken pairs) and match_cnt
// (DIAG pairs with equal bases), cleared on start, held after completion.
module nw_traceback import nw_pkg::*; #(
  parameter int SEQ_LEN  = 4,
  parameter int SCORE_W  = DEF_SCORE_W,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int GAP      = DEF_GAP,
  localparam int IW      = $clog2(SEQ_LEN+1),
  localparam int LW      = $clog2(2*SEQ_LEN+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_traceB,
  input  logic        [2*SEQ_LEN-1:0] seq_a,
  input  logic        [2*SEQ_LEN-1:0] seq_b,
  output logic                      rd_en,
  output logic        [IW-1:0]      rd_i,
  output logic        [IW-1:0]      rd_j,
  input  logic signed [SCORE_W-1:0] rd_score,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [2:0]         out_a,
  output logic        [2:0]         out_b,
`ifdef TB_STATS_EN
  output logic        [LW-1:0]      aln_len,
  output logic        [IW-1:0]      match_cnt,
`endif
  output logic                      end_traceB
);
  state_t state;
  move_t  mv, edge_mv;
  logic [IW-1:0] i, j, nxt_i, nxt_j, sel_i, sel_j;
  logic signed [SCORE_W-1:0] cur, d, u, d_in, u_in;
  logic [1:0] base_a, base_b;
  logic [2:0] pair_a, pair_b;
  logic diag_ok, up_ok, at_origin, on_edge;
  logic rearm;  // set after completion; blocks restart until en_traceB falls

  // Coordinates after the move being handshaken in EMIT.
  always_comb begin
    nxt_i = i;
    nxt_j = j;
    if (mv != LEFT) nxt_i = i - IW'(1);
    if (mv != UP)   nxt_j = j - IW'(1);
  end

  // Step selection runs both from WAIT_CUR (current cell) and on the EMIT
  // handshake (next cell), so the decider sees whichever applies.
  assign sel_i = (state == EMIT) ? nxt_i : i;
  assign sel_j = (state == EMIT) ? nxt_j : j;

  // Neighbour scores are compared in the cycle they arrive, before latching.
  assign d_in = (state == WAIT_DIAG) ? rd_score : d;
  assign u_in = (state == WAIT_UP)   ? rd_score : u;

  always_comb begin
    base_a = '0;
    base_b = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (sel_i == IW'(k+1)) base_a = seq_a[2*k +: 2];
      if (sel_j == IW'(k+1)) base_b = seq_b[2*k +: 2];
    end
  end

  nw_tb_decide #(
    .SCORE_W(SCORE_W), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP), .IW(IW)
  ) u_decide (
    .cur(cur), .d(d_in), .u(u_in), .i(sel_i), .j(sel_j),
    .base_a(base_a), .base_b(base_b), .mv(mv),
    .diag_ok(diag_ok), .up_ok(up_ok), .at_origin(at_origin), .on_edge(on_edge),
    .edge_mv(edge_mv), .pair_a(pair_a), .pair_b(pair_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE; mv <= DIAG; rearm <= 1'b0;
      rd_en <= 1'b0; rd_i <= '0; rd_j <= '0;
      out_valid <= 1'b0; out_a <= '0; out_b <= '0; end_traceB <= 1'b0;
      i <= '0; j <= '0; cur <= '0; d <= '0; u <= '0;
`ifdef TB_STATS_EN
      aln_len <= '0; match_cnt <= '0;
`endif
    end else if (state != IDLE && !en_traceB) begin
      state <= IDLE; rd_en <= 1'b0; out_valid <= 1'b0; end_traceB <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          end_traceB <= 1'b0;
          if (!en_traceB) rearm <= 1'b0;
          else if (!rearm) begin
            i <= IW'(SEQ_LEN); j <= IW'(SEQ_LEN);
            rd_en <= 1'b1; rd_i <= IW'(SEQ_LEN); rd_j <= IW'(SEQ_LEN);
            state <= RD_CUR;
`ifdef TB_STATS_EN
            aln_len <= '0; match_cnt <= '0;
`endif
          end
        end
        RD_CUR:  begin rd_en <= 1'b0; state <= WAIT_CUR;  end
        RD_DIAG: begin rd_en <= 1'b0; state <= WAIT_DIAG; end
        RD_UP:   begin rd_en <= 1'b0; state <= WAIT_UP;   end
        WAIT_DIAG: begin
          d <= rd_score;
          if (diag_ok) begin mv <= DIAG; state <= DECIDE; end
          else begin rd_en <= 1'b1; rd_i <= i - IW'(1); rd_j <= j; state <= RD_UP; end
        end
        WAIT_UP: begin
          u <= rd_score;
          mv <= up_ok ? UP : LEFT;
          state <= DECIDE;
        end
        DECIDE: begin
          out_a <= pair_a; out_b <= pair_b; out_valid <= 1'b1; state <= EMIT;
        end
        DONE: begin
          end_traceB <= 1'b0; rearm <= 1'b1; state <= IDLE;
        end
        default: begin  // WAIT_CUR and EMIT share step selection
          if (state == WAIT_CUR) cur <= rd_score;
          if (state == EMIT && !out_ready) begin
            state <= EMIT;
          end else begin
            if (state == EMIT) begin
              out_valid <= 1'b0; i <= nxt_i; j <= nxt_j;
              if (mv == DIAG) cur <= d;
              if (mv == UP)   cur <= u;
`ifdef TB_STATS_EN
              aln_len <= aln_len + LW'(1);
              if (mv == DIAG && out_a == out_b) match_cnt <= match_cnt + IW'(1);
`endif
            end
            if (state == EMIT && mv == LEFT) begin
              rd_en <= 1'b1; rd_i <= nxt_i; rd_j <= nxt_j; state <= RD_CUR;
            end else if (at_origin) begin
              end_traceB <= 1'b1; state <= DONE;
            end else if (on_edge) begin
              mv <= edge_mv; state <= DECIDE;
            end else begin
              rd_en <= 1'b1; rd_i <= sel_i - IW'(1); rd_j <= sel_j - IW'(1);
              state <= RD_DIAG;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nw_traceback.sv
// tb_nw_traceback: bench for nw_traceback. Holds the score matrix as an
// integer array, answers reads one cycle later, and predicts the pair stream
// by walking the matrix with the scoring rules directly.
// Honours TB_STATS_EN for the optional aln_len / match_cnt outputs.
module tb_nw_traceback;
  import nw_pkg::*;
  localparam int N  = 4;
  localparam int SW = 8;
  localparam int IW = $clog2(N+1);

  logic clk = 1'b0, rst = 1'b0, en_traceB = 1'b0, out_ready = 1'b0;
  logic [2*N-1:0] seq_a = '0, seq_b = '0;
  logic rd_en, out_valid, end_traceB;
  logic [IW-1:0] rd_i, rd_j;
  logic signed [SW-1:0] rd_score = '0;
  logic [2:0] out_a, out_b;
`ifdef TB_STATS_EN
  logic [$clog2(2*N+1)-1:0] aln_len;
  logic [IW-1:0] match_cnt;
`endif

  int n_cmp = 0, n_bad = 0;
  int mat [0:N][0:N];
  int sa [N], sb [N];
  int exp_a[$], exp_b[$];
  int exp_match;

  nw_traceback #(.SEQ_LEN(N)) dut (
    .clk(clk), .rst(rst), .en_traceB(en_traceB), .seq_a(seq_a), .seq_b(seq_b),
    .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j), .rd_score(rd_score),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
`ifdef TB_STATS_EN
    .aln_len(aln_len), .match_cnt(match_cnt),
`endif
    .end_traceB(end_traceB)
  );

  always #5 clk = ~clk;

  // Matrix memory: one cycle read latency.
  always @(posedge clk)
    rd_score <= (rd_en && rd_i <= N && rd_j <= N) ? SW'(mat[rd_i][rd_j]) : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Stream/read rules checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("rd_with_valid", 32'(rd_en & out_valid), 0);
      if (rd_en) chk("rd_in_range", 32'(rd_i <= N && rd_j <= N), 1);
    end
  end

  // Load sequences, optionally fill the matrix, and predict the pair stream.
  task automatic prep(input bit fill);
    int i, j, s, best;
    for (int k = 0; k < N; k++) begin
      seq_a[2*k +: 2] = 2'(sa[k]);
      seq_b[2*k +: 2] = 2'(sb[k]);
    end
    if (fill) begin
      for (int k = 0; k <= N; k++) begin mat[k][0] = -k; mat[0][k] = -k; end
      for (int r = 1; r <= N; r++)
        for (int c = 1; c <= N; c++) begin
          s = (sa[r-1] == sb[c-1]) ? 1 : -1;
          best = mat[r-1][c-1] + s;
          if (mat[r-1][c] - 1 > best) best = mat[r-1][c] - 1;
          if (mat[r][c-1] - 1 > best) best = mat[r][c-1] - 1;
          mat[r][c] = best;
        end
    end
    exp_a.delete(); exp_b.delete(); exp_match = 0;
    i = N; j = N;
    while (i > 0 || j > 0) begin
      if (i > 0 && j > 0 && mat[i][j] == mat[i-1][j-1] + ((sa[i-1] == sb[j-1]) ? 1 : -1)) begin
        exp_a.push_back(sa[i-1]); exp_b.push_back(sb[j-1]);
        if (sa[i-1] == sb[j-1]) exp_match++;
        i--; j--;
      end else if (j == 0 || (i > 0 && mat[i][j] == mat[i-1][j] - 1)) begin
        exp_a.push_back(sa[i-1]); exp_b.push_back(int'(GAP_SYM)); i--;
      end else begin
        exp_a.push_back(int'(GAP_SYM)); exp_b.push_back(sb[j-1]); j--;
      end
    end
  endtask

  // Run one walk; stall_pair gets 5 cycles of backpressure; abort_pair>0
  // drops en_traceB right after that many handshakes.
  task automatic run_walk(input int stall_pair, input int abort_pair,
                          output int npairs, output bit got_end);
    int cyc, stall;
    bit first_rd;
    logic [2:0] ha, hb;
    npairs = 0; got_end = 0; stall = 0; first_rd = 1; cyc = 0; ha = '0; hb = '0;
    en_traceB = 1'b1; out_ready = 1'b0;
    while (cyc < 400 && !got_end) begin
      @(negedge clk); cyc++;
      if (first_rd && rd_en) begin
        first_rd = 0;
        chk("first_rd_i", rd_i, N);
        chk("first_rd_j", rd_j, N);
      end
      if (end_traceB) begin
        got_end = 1; out_ready = 1'b0;
        chk("pairs_at_end", npairs, exp_a.size());
`ifdef TB_STATS_EN
        chk("aln_len", aln_len, exp_a.size());
        chk("match_cnt", match_cnt, exp_match);
`endif
      end else if (out_valid) begin
        if (npairs == stall_pair && stall < 5) begin
          if (stall == 0) begin ha = out_a; hb = out_b; end
          else begin chk("stall_hold_a", out_a, ha); chk("stall_hold_b", out_b, hb); end
          chk("stall_no_rd", rd_en, 0);
          stall++; out_ready = 1'b0;
        end else begin
          if (npairs < exp_a.size()) begin
            chk("pair_a", out_a, exp_a[npairs]);
            chk("pair_b", out_b, exp_b[npairs]);
          end else chk("extra_pair", npairs, exp_a.size());
          out_ready = 1'b1; npairs++;
          if (npairs == abort_pair) begin
            @(negedge clk);
            en_traceB = 1'b0; out_ready = 1'b0;
            return;
          end
        end
      end else out_ready = 1'b0;
    end
    out_ready = 1'b0;
    if (abort_pair == 0) chk("end_seen", got_end, 1);
  endtask

  // After completion: one-cycle pulse, no restart while enable stays high.
  task automatic post_walk();
    @(negedge clk);
    chk("end_one_cycle", end_traceB, 0);
    repeat (3) begin @(negedge clk); chk("no_restart", rd_en, 0); end
    en_traceB = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int np;
    bit ge;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);   chk("rst_out_valid", out_valid, 0);
    chk("rst_end", end_traceB, 0); chk("rst_rd_i", rd_i, 0);
    chk("rst_rd_j", rd_j, 0);      chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    rst = 1'b1;

    // ACGT vs ACGT: four matches.
    sa = '{BASE_A, BASE_C, BASE_G, BASE_T}; sb = sa;
    prep(1);
    run_walk(-1, 0, np, ge);
    chk("acgt_pairs", np, 4);
    post_walk();

    // AAAA vs CCCC: four diagonal mismatches.
    sa = '{BASE_A, BASE_A, BASE_A, BASE_A}; sb = '{BASE_C, BASE_C, BASE_C, BASE_C};
    prep(1);
    run_walk(1, 0, np, ge);
    chk("aaaa_pairs", np, 4);
    post_walk();

    // Crafted: UP down column N to row 0, then LEFT along row 0.
    foreach (sa[k]) begin sa[k] = $urandom_range(0, 3); sb[k] = $urandom_range(0, 3); end
    for (int r = 0; r <= N; r++)
      for (int c = 0; c <= N; c++) mat[r][c] = 100;
    for (int r = 0; r <= N; r++) mat[r][N] = 10 - r;
    prep(0);
    run_walk(-1, 0, np, ge);
    chk("crafted_pairs", np, 8);
    post_walk();

    // Random sequences with backpressure on a random pair.
    for (int t = 0; t < 6; t++) begin
      foreach (sa[k]) begin sa[k] = $urandom_range(0, 3); sb[k] = $urandom_range(0, 3); end
      prep(1);
      run_walk($urandom_range(0, 3), 0, np, ge);
      post_walk();
    end

    // Abort after the second pair, then a full restart.
    foreach (sa[k]) begin sa[k] = $urandom_range(0, 3); sb[k] = $urandom_range(0, 3); end
    prep(1);
    run_walk(-1, 2, np, ge);
    chk("abort_end_none", ge, 0);
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_rd", rd_en, 0);
    repeat (4) begin @(negedge clk); chk("abort_no_end", end_traceB, 0); end
    run_walk(-1, 0, np, ge);
    post_walk();

    // Reset for one edge while waiting on the first diagonal read.
    foreach (sa[k]) begin sa[k] = $urandom_range(0, 3); sb[k] = $urandom_range(0, 3); end
    prep(1);
    en_traceB = 1'b1;
    begin
      int w;
      w = 0;
      do begin @(negedge clk); w++; end
      while (!(rd_en && rd_i == N-1 && rd_j == N-1) && w < 50);
      chk("diag_rd_seen", 32'(w < 50), 1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd_en", rd_en, 0);  chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_end", end_traceB, 0); chk("mid_rst_rd_i", rd_i, 0);
    chk("mid_rst_rd_j", rd_j, 0);    chk("mid_rst_a", out_a, 0);
    chk("mid_rst_b", out_b, 0);
    rst = 1'b1;
    run_walk(-1, 0, np, ge);
    post_walk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
